// File: rtl/hog_frame_ctrl_if.sv
// Row stream handshake between the frame source and hog_frame_ctrl.
// The source presents one full row per beat; the controller accepts it when row_ready is high.
interface hog_frame_ctrl_if #(
  parameter int ROW_W = 560
) ();
  logic             row_valid;
  logic             row_ready;
  logic [ROW_W-1:0] row_data;

  modport master (output row_valid, output row_data, input row_ready);
  modport slave  (input row_valid, input row_data, output row_ready);
endinterface

// File: rtl/hog_frame_ctrl.sv
// Frame sequencer for the denoise/HOG/sqrt pipeline: pipeline reset, bubble-free row load,
// zero-row flush, then drain with output-beat counting, timeout and underrun detection.
module hog_frame_ctrl #(
  parameter int PIX_W        = 8,
  parameter int ROW_PIX      = 70,
  parameter int N_ROWS       = 160,
  parameter int FLUSH_CYC    = 4,
  parameter int OUT_CNT      = 8480,
  parameter int TIMEOUT      = 1024,
  parameter int PIPE_RST_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode_in,
  hog_frame_ctrl_if.slave          src,
  output logic                     pipe_rst_n,
  output logic                     pipe_mode,
  output logic [PIX_W*ROW_PIX-1:0] pipe_pixel,
  input  logic                     pipe_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [7:0]               rows_in,
  output logic [15:0]              outs_seen
);

  localparam int CNT_MAX0 = (TIMEOUT > FLUSH_CYC) ? TIMEOUT : FLUSH_CYC;
  localparam int CNT_MAX  = (CNT_MAX0 > PIPE_RST_CYC) ? CNT_MAX0 : PIPE_RST_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX) + 1;

  typedef enum logic [2:0] {
    IDLE,
    PRST,
    LOAD,
    FLUSH,
    DRAIN,
    DONE,
    ERR
  } state_t;

  state_t           state;
  state_t           next;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             counting;

  assign accept   = (state == LOAD) && src.row_valid;
  assign counting = (state == LOAD) || (state == FLUSH) || (state == DRAIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next;
      // cnt measures time spent in the current state; restarts on every transition
      cnt   <= (next != state) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:  if (start) next = PRST;
      PRST:  if (cnt == CNT_W'(PIPE_RST_CYC - 1)) next = LOAD;
      LOAD: begin
        if (!src.row_valid)                 next = ERR;
        else if (rows_in == 8'(N_ROWS - 1)) next = FLUSH;
      end
      FLUSH: if (cnt == CNT_W'(FLUSH_CYC - 1)) next = DRAIN;
      DRAIN: begin
        if (outs_seen >= 16'(OUT_CNT))         next = DONE;
        else if (cnt == CNT_W'(TIMEOUT - 1))   next = ERR;
      end
      DONE:    next = IDLE;
      ERR:     next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src.row_ready <= 1'b0;
      pipe_rst_n    <= 1'b0;
      pipe_mode     <= 1'b0;
      pipe_pixel    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= 2'd0;
      rows_in       <= '0;
      outs_seen     <= '0;
    end else begin
      src.row_ready <= (next == LOAD);
      pipe_rst_n    <= (next == LOAD) || (next == FLUSH) || (next == DRAIN);
      busy          <= (next != IDLE);
      done          <= (next == DONE);
      pipe_pixel    <= accept ? src.row_data : '0;

      if ((state == IDLE) && start) begin
        pipe_mode <= mode_in;
        rows_in   <= '0;
        outs_seen <= '0;
        err       <= 1'b0;
        err_code  <= 2'd0;
      end else begin
        if (accept) rows_in <= rows_in + 8'd1;
        if (counting && pipe_valid && (outs_seen < 16'(OUT_CNT)))
          outs_seen <= outs_seen + 16'd1;
        if ((next == ERR) && (state != ERR)) begin
          err      <= 1'b1;
          err_code <= (state == LOAD) ? 2'd1 : 2'd2;
        end
      end
    end
  end

endmodule

// File: tb/tb_hog_frame_ctrl.sv
// Self-checking bench for hog_frame_ctrl with a small frame geometry.
// Row data is scoreboarded against pipe_pixel; frame timing comes from a cycle model below.
module tb_hog_frame_ctrl;

  localparam int PIX_W   = 8;
  localparam int ROW_PIX = 70;
  localparam int ROW_W   = PIX_W * ROW_PIX;
  localparam int NR      = 4;
  localparam int OC      = 3;
  localparam int FC      = 2;
  localparam int TO      = 8;
  localparam int PR      = 2;
  localparam int L0      = 1 + PR;       // first LOAD cycle after start at cycle 0
  localparam int L1      = L0 + NR - 1;  // last LOAD cycle
  localparam int F0      = L1 + 1;       // first FLUSH cycle
  localparam int D0      = F0 + FC;      // first DRAIN cycle

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             mode_in = 1'b0;
  logic             pipe_valid = 1'b0;
  logic             pipe_rst_n;
  logic             pipe_mode;
  logic [ROW_W-1:0] pipe_pixel;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [7:0]       rows_in;
  logic [15:0]      outs_seen;

  hog_frame_ctrl_if #(.ROW_W(ROW_W)) src ();

  hog_frame_ctrl #(
    .PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .N_ROWS(NR), .FLUSH_CYC(FC),
    .OUT_CNT(OC), .TIMEOUT(TO), .PIPE_RST_CYC(PR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in), .src(src),
    .pipe_rst_n(pipe_rst_n), .pipe_mode(pipe_mode), .pipe_pixel(pipe_pixel),
    .pipe_valid(pipe_valid), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .rows_in(rows_in), .outs_seen(outs_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [ROW_W-1:0] px_q[$];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check_eq(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [575:0] tmp;
    for (int i = 0; i < 18; i++) tmp[i*32 +: 32] = $urandom;
    return tmp[ROW_W-1:0];
  endfunction

  task automatic check_reset_vals(input string name);
    check_eq({name, " row_ready"}, src.row_ready, 0);
    check_eq({name, " pipe_rst_n"}, pipe_rst_n, 0);
    check_eq({name, " pipe_mode"}, pipe_mode, 0);
    check_eq({name, " pipe_pixel"}, pipe_pixel, 0);
    check_eq({name, " busy"}, busy, 0);
    check_eq({name, " done"}, done, 0);
    check_eq({name, " err"}, err, 0);
    check_eq({name, " err_code"}, err_code, 0);
    check_eq({name, " rows_in"}, rows_in, 0);
    check_eq({name, " outs_seen"}, outs_seen, 0);
  endtask

  // Runs one frame with start at relative cycle 0 and checks every output each cycle.
  task automatic run_frame(input logic mode, input bit tog, input int under,
                           input int pstart, input int npulse, input bit mid_start,
                           input string name);
    int end_c, outs_m, rows_m, dc0, n;
    bit e_err;
    logic [1:0] e_code;
    logic [ROW_W-1:0] rd, exp_px;

    if (under >= 0) begin
      end_c = L0 + under + 1; e_err = 1'b1; e_code = 2'd1;
    end else begin
      end_c = D0 + TO; e_err = 1'b1; e_code = 2'd2;
      for (int d = D0; d < D0 + TO; d++) begin
        n = 0;
        for (int p = pstart; p < pstart + npulse; p++) if (p >= L0 && p < d) n++;
        if (n >= OC) begin
          end_c = d + 1; e_err = 1'b0; e_code = 2'd0;
          break;
        end
      end
    end

    px_q.delete();
    outs_m = 0;
    rows_m = 0;
    dc0 = done_cnt;
    for (int c = 0; c <= end_c + 1; c++) begin
      tick();
      if (c >= 1) begin
        exp_px = px_q.pop_front();
        check_eq({name, " pixel"}, pipe_pixel, exp_px);
        check_eq({name, " rows_in"}, rows_in, rows_m);
        check_eq({name, " outs_seen"}, outs_seen, outs_m);
        check_eq({name, " pipe_mode"}, pipe_mode, mode);
        check_eq({name, " row_ready"}, src.row_ready, (c >= L0 && c <= L1 && c < end_c));
        check_eq({name, " pipe_rst_n"}, pipe_rst_n, (c >= L0 && c < end_c));
        check_eq({name, " busy"}, busy, (c <= end_c));
        check_eq({name, " done"}, done, (c == end_c && !e_err));
        check_eq({name, " err"}, err, (c >= end_c && e_err));
        check_eq({name, " err_code"}, err_code, (c >= end_c) ? e_code : 2'd0);
      end
      start   = (c == 0) || (mid_start && c == L0 + 1);
      mode_in = (c == 0) ? mode : (tog ? ~mode_in : mode_in);
      src.row_valid = (c >= L0 && c <= L1 && (under < 0 || c < L0 + under));
      rd = rand_row();
      src.row_data = rd;
      pipe_valid = (c >= pstart && c < pstart + npulse);
      if (src.row_valid && c < end_c) begin
        px_q.push_back(rd);
        rows_m++;
      end else begin
        px_q.push_back('0);
      end
      if (pipe_valid && c >= L0 && c < end_c && outs_m < OC) outs_m++;
    end
    check_eq({name, " done pulses"}, done_cnt - dc0, e_err ? 0 : 1);

    start = 1'b0; mode_in = 1'b0; src.row_valid = 1'b0; pipe_valid = 1'b0;
    tick();
    check_eq({name, " idle rows_in hold"}, rows_in, rows_m);
    check_eq({name, " idle outs_seen hold"}, outs_seen, outs_m);
    check_eq({name, " idle err hold"}, err, e_err);
    check_eq({name, " idle busy"}, busy, 0);
  endtask

  initial begin
    int dc0;
    src.row_valid = 1'b0;
    src.row_data  = '0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    run_frame(1'b0, 1'b0, -1, F0, 3, 1'b0, "nominal");
    run_frame(1'b1, 1'b1, -1, F0, 3, 1'b0, "mode_latch");
    run_frame(1'b0, 1'b0, 1, 0, 0, 1'b0, "underrun");
    run_frame(1'b0, 1'b0, -1, F0, 3, 1'b0, "err_clear");
    run_frame(1'b0, 1'b0, -1, F0, 2, 1'b0, "timeout");
    run_frame(1'b1, 1'b0, -1, L0 + 1, 5, 1'b1, "busy_start");

    dc0 = done_cnt;
    for (int c = 0; c <= L0 + 2; c++) begin
      tick();
      if (c == L0 + 2) check_reset_vals("mid_reset");
      start = (c == 0);
      mode_in = 1'b1;
      src.row_valid = (c >= L0);
      src.row_data = rand_row();
      rst_n = !(c == L0 + 1);
    end
    rst_n = 1'b1; start = 1'b0; mode_in = 1'b0; src.row_valid = 1'b0;
    tick();
    check_eq("mid_reset done pulses", done_cnt - dc0, 0);
    check_eq("mid_reset err", err, 0);
    run_frame(1'b0, 1'b0, -1, F0, 3, 1'b0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
